multicycle_controller: RTL and testbench

Main control FSM for the multicycle RISC-V core. It sequences instruction fetch, decode, execute, memory access and writeback over several cycles per instruction, driving datapath multiplexer selects and write enables. Its `alu_op` output feeds the ALU controller, which combines it with `func3` to form the 3-bit ALU operation. It sits beside the datapath and observes only `op`, `func3` and the ALU `zero`/`neg` flags.

---
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller.sv | 177 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic       zero;
    logic       neg;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [3:0] state;

    modport master (
        input  op, func3, zero, neg,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, state
    );

    modport slave (
        output op, func3, zero, neg,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback and drives the datapath selects/enables.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXE_R     = 4'd6,
        S_EXE_I     = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_LINK      = 4'd13,
        S_UNUSED14  = 4'd14,
        S_UNUSED15  = 4'd15
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       pc_write_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       adr_src_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [2:0] imm_src_c;
    logic       taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        case (bus.func3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.neg;
            3'b101:  taken = ~bus.neg;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = S_FETCH;
        pc_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        imm_src_c    = 3'b000;
        case (state_q)
            S_FETCH: begin
                ir_write_c   = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                pc_write_c   = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // Branch/JAL target is precomputed here into ALUOut.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                imm_src_c   = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_EXE_R;
                    OP_I:         state_d = S_EXE_I;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                imm_src_c   = (bus.op == OP_SW) ? 3'b001 : 3'b000;
                state_d     = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src_c = 1'b1;
                state_d   = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXE_R: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_EXE_I: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                pc_write_c  = taken;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a_c  = 2'b10;
                alu_src_b_c  = 2'b01;
                result_src_c = 2'b10;
                pc_write_c   = 1'b1;
                state_d      = S_LINK;
            end
            S_LINK: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_LUI: begin
                imm_src_c    = 3'b100;
                result_src_c = 2'b11;
                reg_write_c  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are gated by rst directly so nothing is written while held.
    assign bus.pc_write   = pc_write_c  & ~rst;
    assign bus.mem_write  = mem_write_c & ~rst;
    assign bus.ir_write   = ir_write_c  & ~rst;
    assign bus.reg_write  = reg_write_c & ~rst;
    assign bus.adr_src    = adr_src_c;
    assign bus.result_src = result_src_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.imm_src    = imm_src_c;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks every control output per cycle.
module tb_multicycle_controller;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, alu_op, reg_write, imm_src}
    logic [15:0] ctl;
    assign ctl = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                  bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.reg_write, bus.imm_src};

    localparam logic [15:0] C_FETCH   = {4'b1001, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_FETCH_R = {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_DEC_B   = {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b010};
    localparam logic [15:0] C_DEC_J   = {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b011};
    localparam logic [15:0] C_MADR_L  = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_MADR_S  = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b001};
    localparam logic [15:0] C_MREAD   = {4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_MWB     = {4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000};
    localparam logic [15:0] C_MWRITE  = {4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_EXE_R   = {4'b0000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
    localparam logic [15:0] C_EXE_I   = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 3'b000};
    localparam logic [15:0] C_ALU_WB  = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000};
    localparam logic [15:0] C_BR0     = {4'b0000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 3'b000};
    localparam logic [15:0] C_BR1     = {4'b1000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 3'b000};
    localparam logic [15:0] C_JAL     = {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_JALR    = {4'b1000, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_LINK    = {4'b0000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000};
    localparam logic [15:0] C_LUI     = {4'b0000, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 3'b100};

    task automatic test_reset();
        rst = 1'b1;
        bus.op = 7'b0110011; bus.func3 = 3'b000; bus.zero = 1'b0; bus.neg = 1'b0;
        #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL rst_init_state got=%0d want=0", bus.state); end
        total++; if (ctl !== C_FETCH_R) begin bad++; $display("FAIL rst_init_ctl got=%h want=%h", ctl, C_FETCH_R); end
        @(negedge clk); rst = 1'b0;
        // Walk into EXE_R, then assert rst mid-cycle.
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd6) begin bad++; $display("FAIL rst_pre_state got=%0d want=6", bus.state); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL rst_async_state got=%0d want=0", bus.state); end
        total++; if (ctl !== C_FETCH_R) begin bad++; $display("FAIL rst_async_ctl got=%h want=%h", ctl, C_FETCH_R); end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd0 || ctl !== C_FETCH_R) begin
            bad++; $display("FAIL rst_hold got state=%0d ctl=%h want state=0 ctl=%h", bus.state, ctl, C_FETCH_R);
        end
        bus.op = 7'b1111111;
        @(negedge clk); rst = 1'b0;
        #1;
        total++; if (ctl !== C_FETCH) begin bad++; $display("FAIL rst_release_fetch got=%h want=%h", ctl, C_FETCH); end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd1 || ctl !== C_DEC_B) begin
            bad++; $display("FAIL rst_after_fetch got state=%0d ctl=%h want state=1 ctl=%h", bus.state, ctl, C_DEC_B);
        end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL rst_back_fetch got=%0d want=0", bus.state); end
    endtask

    task automatic test_r_type();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        logic [15:0] ec [4] = '{C_FETCH, C_DEC_B, C_EXE_R, C_ALU_WB};
        bus.op = 7'b0110011; bus.func3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL r_state[%0d] got=%0d want=%0d", i, bus.state, es[i]); end
            total++; if (ctl !== ec[i]) begin bad++; $display("FAIL r_ctl[%0d] got=%h want=%h", i, ctl, ec[i]); end
        end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL r_end got=%0d want=0", bus.state); end
    endtask

    task automatic test_i_alu();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd7, 4'd8};
        logic [15:0] ec [4] = '{C_FETCH, C_DEC_B, C_EXE_I, C_ALU_WB};
        bus.op = 7'b0010011; bus.func3 = 3'b110;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            total++; if (bus.state !== es[i]) begin bad++; $display("FAIL i_state[%0d] got=%0d want=%0d", i, bus.state, es[i]); end
            total++; if (ctl !== ec[i]) begin bad++; $display("FAIL i_ctl[%0d] got=%h want=%h", i, ctl, ec[i]); end
        end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL i_end got=%0d want=0", bus.state); end
    endtask

    task automatic test_lw_sw();
        logic [3:0]  ls [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [15:0] lc [5] = '{C_FETCH, C_DEC_B, C_MADR_L, C_MREAD, C_MWB};
        logic [3:0]  ss [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [15:0] sc [4] = '{C_FETCH, C_DEC_B, C_MADR_S, C_MWRITE};
        bus.op = 7'b0000011; bus.func3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            total++; if (bus.state !== ls[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, bus.state, ls[i]); end
            total++; if (ctl !== lc[i]) begin bad++; $display("FAIL lw_ctl[%0d] got=%h want=%h", i, ctl, lc[i]); end
        end
        @(posedge clk);
        bus.op = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            total++; if (bus.state !== ss[i]) begin bad++; $display("FAIL sw_state[%0d] got=%0d want=%0d", i, bus.state, ss[i]); end
            total++; if (ctl !== sc[i]) begin bad++; $display("FAIL sw_ctl[%0d] got=%h want=%h", i, ctl, sc[i]); end
        end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL sw_end got=%0d want=0", bus.state); end
    endtask

    task automatic test_branch();
        // {func3, zero, neg, taken}
        logic [5:0] vec [7] = '{
            {3'b000, 1'b1, 1'b0, 1'b1},
            {3'b000, 1'b0, 1'b0, 1'b0},
            {3'b001, 1'b0, 1'b0, 1'b1},
            {3'b100, 1'b0, 1'b1, 1'b1},
            {3'b101, 1'b0, 1'b1, 1'b0},
            {3'b010, 1'b1, 1'b1, 1'b0},
            {3'b110, 1'b1, 1'b0, 1'b0}
        };
        logic [15:0] exp_br;
        bus.op = 7'b1100011;
        for (int v = 0; v < 7; v++) begin
            bus.func3 = vec[v][5:3]; bus.zero = vec[v][2]; bus.neg = vec[v][1];
            exp_br = vec[v][0] ? C_BR1 : C_BR0;
            #1;
            total++; if (bus.state !== 4'd0 || ctl !== C_FETCH) begin
                bad++; $display("FAIL br%0d_fetch got state=%0d ctl=%h want state=0 ctl=%h", v, bus.state, ctl, C_FETCH);
            end
            @(posedge clk); #1;
            total++; if (bus.state !== 4'd1 || ctl !== C_DEC_B) begin
                bad++; $display("FAIL br%0d_decode got state=%0d ctl=%h want state=1 ctl=%h", v, bus.state, ctl, C_DEC_B);
            end
            @(posedge clk); #1;
            total++; if (bus.state !== 4'd9) begin bad++; $display("FAIL br%0d_state got=%0d want=9", v, bus.state); end
            total++; if (ctl !== exp_br) begin bad++; $display("FAIL br%0d_ctl got=%h want=%h", v, ctl, exp_br); end
            @(posedge clk); #1;
            total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL br%0d_end got=%0d want=0", v, bus.state); end
        end
        bus.zero = 1'b0; bus.neg = 1'b0;
    endtask

    task automatic test_jumps();
        logic [3:0]  js [4] = '{4'd0, 4'd1, 4'd10, 4'd8};
        logic [15:0] jc [4] = '{C_FETCH, C_DEC_J, C_JAL, C_ALU_WB};
        logic [3:0]  rs [5] = '{4'd0, 4'd1, 4'd11, 4'd13, 4'd8};
        logic [15:0] rc [5] = '{C_FETCH, C_DEC_B, C_JALR, C_LINK, C_ALU_WB};
        bus.op = 7'b1101111; bus.func3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            total++; if (bus.state !== js[i]) begin bad++; $display("FAIL jal_state[%0d] got=%0d want=%0d", i, bus.state, js[i]); end
            total++; if (ctl !== jc[i]) begin bad++; $display("FAIL jal_ctl[%0d] got=%h want=%h", i, ctl, jc[i]); end
        end
        @(posedge clk);
        bus.op = 7'b1100111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            total++; if (bus.state !== rs[i]) begin bad++; $display("FAIL jalr_state[%0d] got=%0d want=%0d", i, bus.state, rs[i]); end
            total++; if (ctl !== rc[i]) begin bad++; $display("FAIL jalr_ctl[%0d] got=%h want=%h", i, ctl, rc[i]); end
        end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL jalr_end got=%0d want=0", bus.state); end
    endtask

    task automatic test_lui_illegal();
        logic [3:0]  us [3] = '{4'd0, 4'd1, 4'd12};
        logic [15:0] uc [3] = '{C_FETCH, C_DEC_B, C_LUI};
        bus.op = 7'b0110111;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            total++; if (bus.state !== us[i]) begin bad++; $display("FAIL lui_state[%0d] got=%0d want=%0d", i, bus.state, us[i]); end
            total++; if (ctl !== uc[i]) begin bad++; $display("FAIL lui_ctl[%0d] got=%h want=%h", i, ctl, uc[i]); end
        end
        @(posedge clk);
        bus.op = 7'b1111111;
        #1;
        total++; if (bus.state !== 4'd0 || ctl !== C_FETCH) begin
            bad++; $display("FAIL ill_fetch got state=%0d ctl=%h want state=0 ctl=%h", bus.state, ctl, C_FETCH);
        end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd1 || ctl !== C_DEC_B) begin
            bad++; $display("FAIL ill_decode got state=%0d ctl=%h want state=1 ctl=%h", bus.state, ctl, C_DEC_B);
        end
        @(posedge clk); #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL ill_end got=%0d want=0", bus.state); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_r_type();
        test_i_alu();
        test_lw_sw();
        test_branch();
        test_jumps();
        test_lui_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
